instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch-side front end of the 8-bit pipelined processor; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues reads to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instruction bytes in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports flush/redirect (taken branch or jump) and halt.

Parameters:
- DATA_W, 8, instruction width in bits.
- ADDR_W, 8, PC / instruction memory address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- imem_en  output  1  read strobe to instruction memory.
- imem_addr  output  ADDR_W  read address, valid when imem_en=1.
- imem_rdata  input  DATA_W  read data, valid the cycle after imem_en=1.
- instr  output  DATA_W  head-of-FIFO instruction.
- instr_pc  output  ADDR_W  PC of instr.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  decode accepts instr this cycle.
- flush  input  1  discard queued and in-flight fetches; redirect.
- flush_pc  input  ADDR_W  new PC, sampled when flush=1.
- halt  input  1  stop issuing new fetches (level).
- count  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; FIFO empty; in-flight flag cleared; state=BOOT.
  - Outputs: imem_en=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, count=0.
- State machine:
  - BOOT: one idle cycle after reset deasserts, no issue. Then goes to RUN, or to HOLD if halt=1.
  - RUN: issues fetches. Goes to HOLD when halt=1.
  - HOLD: no new issue. Returns to RUN when halt=0.
  - flush is honoured in every state and does not change state.
- Issue rule (RUN only): imem_en=1 iff count + inflight < DEPTH, where inflight is 1 if a read was issued last cycle and not cancelled.
  - On issue: imem_addr=pc, pc<=pc+1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - The PC of each issued read is registered alongside the in-flight flag.
- Return: the cycle after an issue, imem_rdata and its PC are pushed into the FIFO tail, unless cancelled by flush.
  - The credit check guarantees a push never hits a full FIFO; no overflow path exists.
- Pop: when instr_valid=1 and instr_ready=1, the head is removed at the clock edge.
  - instr/instr_pc come from a registered head with no combinational path from imem_rdata. An entry pushed at edge N is visible at instr from cycle N+1.
  - Minimum latency from issue to instr_valid is 2 cycles.
- Simultaneous push and pop: count is unchanged and ordering is preserved. With DEPTH entries full and a pop, no push can occur, because the credit check blocked the issue.
- Pop when empty: ignored. instr_ready with instr_valid=0 has no effect.
- Flush (flush=1 at an edge):
  - FIFO emptied, count=0, in-flight read discarded (its data is never pushed), pc<=flush_pc.
  - No issue occurs in the flush cycle. The first fetch from flush_pc is issued the next cycle if in RUN.
  - Any pop requested in the same cycle is ignored.
- Flush during HOLD: pc updates; the first fetch from flush_pc is issued when halt drops.
- Halt: an in-flight read still completes and is pushed. Queued entries keep draining to decode.
- Reset mid-operation: asynchronous clear to the reset values above. Any pending memory read data is ignored.
- Steady state with instr_ready=1 continuously: one instruction per cycle.
- count is always in 0..DEPTH. instr_valid = (count != 0).

Test Plan:
1. Reset release, memory[0..5]=0x41,0x82,0x03,0xC4,0x05,0x46, instr_ready=1:
   - No issue in BOOT.
   - imem_addr 0,1,2… on consecutive cycles.
   - instr_valid first high 3 cycles after release with instr=0x41, instr_pc=0; then one instruction per cycle in order.
2. instr_ready=0 from the start:
   - Exactly 4 issues (addresses 0–3), count reaches 4, imem_en stays 0.
   - Raising instr_ready: pops resume and the next issue is address 4 the cycle after the first pop.
3. Flush with flush_pc=0x20 while count=3 and a read is in flight:
   - Next cycle count=0, instr_valid=0, and the stale read is never observed at instr.
   - The next issued address is 0x20; instr_pc=0x20 reaches instr 2 cycles after that issue.
4. halt=1 mid-stream:
   - imem_en drops the same cycle.
   - The in-flight entry is still pushed; the FIFO drains to 0.
   - Dropping halt resumes at the next sequential PC with no gap or duplicate.
5. PC wrap with reset via flush to flush_pc=0xFE, instr_ready=1:
   - Fetched PCs are 0xFE, 0xFF, 0x00, 0x01.
   - instr_pc matches each instruction.
6. Assert reset low while count=2:
   - instr_valid, imem_en and count go to 0 immediately, without waiting for a clock edge.
   - After release, fetch restarts at RESET_PC following the BOOT cycle.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC owner and fetch FIFO feeding decode with a valid/ready handshake.
// Ports:
//   clk, reset (async, active-low)
//   imem_en/imem_addr -> synchronous instruction memory, imem_rdata returns one cycle later
//   instr/instr_pc/instr_valid/instr_ready -> decode handshake on the FIFO head
//   flush/flush_pc -> discard queued and in-flight fetches, redirect PC
//   halt -> stop issuing new fetches (level); count -> FIFO occupancy
module instr_fetch_queue #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_en,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [DATA_W-1:0]          imem_rdata,
   output logic [DATA_W-1:0]          instr,
   output logic [ADDR_W-1:0]          instr_pc,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   input  logic                       flush,
   input  logic [ADDR_W-1:0]          flush_pc,
   input  logic                       halt,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] pc, inflight_pc;
   logic inflight, push, pop;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W:0] used;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q [DEPTH];
   // credit check: queued entries plus the read still in flight must leave room
   assign used = {1'b0, count} + (CNT_W+1)'(inflight);
   assign push = inflight && !flush;
   assign pop = instr_valid && instr_ready && !flush;
   assign imem_addr = pc;
   assign instr_valid = count != '0;
   // head is registered storage; masked so an empty queue presents zeros
   assign instr = instr_valid ? data_q[rd_ptr] : '0;
   assign instr_pc = instr_valid ? pc_q[rd_ptr] : '0;
   always_comb begin
      state_nxt = halt ? HOLD : RUN;
      imem_en = (state == RUN) && !halt && !flush && (used < (CNT_W+1)'(DEPTH));
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
         pc <= RESET_PC;
         inflight <= 1'b0;
         inflight_pc <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         inflight <= imem_en;
         if (imem_en) inflight_pc <= pc;
         if (flush) begin
            pc <= flush_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
         end else begin
            if (imem_en) pc <= pc + ADDR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr] <= imem_rdata;
         pc_q[wr_ptr] <= inflight_pc;
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fetch issue, FIFO return, flush, halt, wrap and async reset.
module tb_instr_fetch_queue;
   logic clk, reset, imem_en, instr_valid, instr_ready, flush, halt;
   logic [7:0] imem_addr, imem_rdata, instr, instr_pc, flush_pc;
   logic [2:0] count;
   logic [7:0] mem [256];
   int n_cmp, n_err;

   instr_fetch_queue dut (
      .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush),
      .flush_pc(flush_pc), .halt(halt), .count(count)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      imem_rdata = 0;
      reset = 1; instr_ready = 1; flush = 0; flush_pc = 0; halt = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
      mem[0] = 8'h41; mem[1] = 8'h82; mem[2] = 8'h03;
      mem[3] = 8'hC4; mem[4] = 8'h05; mem[5] = 8'h46;
      #1 reset = 0;
      #1;
      chk("rst_en", imem_en, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_count", count, 0);

      // 1: boot then one instruction per cycle
      tick; tick; reset = 1; #1;
      chk("t1_boot_en", imem_en, 0);
      tick;
      for (int k = 0; k < 8; k++) begin
         chk("t1_en", imem_en, 1);
         chk("t1_addr", imem_addr, k);
         if (k >= 2) begin
            chk("t1_valid", instr_valid, 1);
            chk("t1_instr", instr, mem[k-2]);
            chk("t1_ipc", instr_pc, k - 2);
            chk("t1_count", count, 1);
         end else chk("t1_novalid", instr_valid, 0);
         tick;
      end

      // 2: decode stalled fills the queue, then drains
      instr_ready = 0; reset = 0; #1; tick; reset = 1; #1;
      chk("t2_boot_en", imem_en, 0);
      tick;
      for (int k = 0; k < 4; k++) begin
         chk("t2_en", imem_en, 1);
         chk("t2_addr", imem_addr, k);
         tick;
      end
      chk("t2_count3", count, 3);
      chk("t2_en_off", imem_en, 0);
      tick;
      chk("t2_count4", count, 4);
      chk("t2_en_full", imem_en, 0);
      chk("t2_head", instr, mem[0]);
      chk("t2_head_pc", instr_pc, 0);
      tick;
      chk("t2_count4b", count, 4);
      chk("t2_en_fullb", imem_en, 0);
      instr_ready = 1; #1;
      chk("t2_en_prepop", imem_en, 0);
      tick;
      chk("t2_pop_count", count, 3);
      chk("t2_pop_en", imem_en, 1);
      chk("t2_pop_addr", imem_addr, 4);
      chk("t2_pop_instr", instr, mem[1]);
      chk("t2_pop_pc", instr_pc, 1);
      tick;
      chk("t2_p2_count", count, 2);
      chk("t2_p2_addr", imem_addr, 5);
      chk("t2_p2_pc", instr_pc, 2);

      // 3: flush with three queued and one in flight
      instr_ready = 0; reset = 0; #1; tick; reset = 1; #1;
      tick; tick; tick; tick; tick;
      chk("t3_count3", count, 3);
      chk("t3_pre_en", imem_en, 0);
      flush = 1; flush_pc = 8'h20; #1;
      chk("t3_flush_en", imem_en, 0);
      tick; flush = 0; #1;
      chk("t3_count0", count, 0);
      chk("t3_valid0", instr_valid, 0);
      chk("t3_en", imem_en, 1);
      chk("t3_addr", imem_addr, 8'h20);
      instr_ready = 1;
      tick;
      chk("t3_addr21", imem_addr, 8'h21);
      chk("t3_stale", instr_valid, 0);
      tick;
      chk("t3_valid", instr_valid, 1);
      chk("t3_ipc", instr_pc, 8'h20);
      chk("t3_instr", instr, mem[8'h20]);

      // 4: halt mid-stream
      halt = 1; #1;
      chk("t4_en_drop", imem_en, 0);
      tick;
      chk("t4_inflight_pc", instr_pc, 8'h21);
      chk("t4_count1", count, 1);
      chk("t4_en_hold", imem_en, 0);
      tick;
      chk("t4_drained", count, 0);
      chk("t4_valid0", instr_valid, 0);
      tick;
      chk("t4_en_hold2", imem_en, 0);
      halt = 0; #1;
      chk("t4_en_hold3", imem_en, 0);
      tick;
      chk("t4_resume_en", imem_en, 1);
      chk("t4_resume_addr", imem_addr, 8'h22);
      tick;
      chk("t4_next_addr", imem_addr, 8'h23);
      tick;
      chk("t4_ipc", instr_pc, 8'h22);
      chk("t4_instr", instr, mem[8'h22]);

      // 5: PC wrap
      flush = 1; flush_pc = 8'hFE; #1;
      chk("t5_flush_en", imem_en, 0);
      tick; flush = 0; #1;
      chk("t5_count0", count, 0);
      chk("t5_addr_fe", imem_addr, 8'hFE);
      tick;
      chk("t5_addr_ff", imem_addr, 8'hFF);
      tick;
      chk("t5_addr_00", imem_addr, 8'h00);
      chk("t5_ipc_fe", instr_pc, 8'hFE);
      chk("t5_instr_fe", instr, mem[8'hFE]);
      tick;
      chk("t5_addr_01", imem_addr, 8'h01);
      chk("t5_ipc_ff", instr_pc, 8'hFF);
      chk("t5_instr_ff", instr, mem[8'hFF]);
      tick;
      chk("t5_ipc_00", instr_pc, 8'h00);
      chk("t5_instr_00", instr, 8'h41);
      tick;
      chk("t5_ipc_01", instr_pc, 8'h01);
      chk("t5_instr_01", instr, 8'h82);

      // 6: asynchronous reset with two queued
      instr_ready = 0; reset = 0; #1; tick; reset = 1; #1;
      tick; tick; tick; tick;
      chk("t6_count2", count, 2);
      chk("t6_en_pre", imem_en, 1);
      #2 reset = 0;
      #1;
      chk("t6_async_valid", instr_valid, 0);
      chk("t6_async_en", imem_en, 0);
      chk("t6_async_count", count, 0);
      chk("t6_async_addr", imem_addr, 0);
      tick; reset = 1; instr_ready = 1; #1;
      chk("t6_boot_en", imem_en, 0);
      tick;
      chk("t6_en", imem_en, 1);
      chk("t6_addr", imem_addr, 0);
      tick; tick;
      chk("t6_valid", instr_valid, 1);
      chk("t6_instr", instr, 8'h41);
      chk("t6_ipc", instr_pc, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
